// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-wide, byte-addressed data memory port.
// Handles RV32I load extension and read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  mem_write_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i
);

  typedef enum logic [2:0] {StIdle, StLoad, StMerge, StWrite, StDone} state_e;

  state_e                state_q;
  logic                  ready_q;
  logic                  resp_q;
  logic [DATA_WIDTH-1:0] load_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] store_q;
  logic [DATA_WIDTH-1:0] merge_q;

  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    load_ext = mem_read_data_i;
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){mem_read_data_i[7]}}, mem_read_data_i[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){mem_read_data_i[15]}}, mem_read_data_i[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, mem_read_data_i[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, mem_read_data_i[15:0]};
      default: load_ext = mem_read_data_i;
    endcase
  end

  // Only SB/SH reach MERGE, so funct3[0] alone selects byte vs halfword.
  always_comb begin
    merged = mem_read_data_i;
    if (funct3_q[0]) begin
      merged[15:0] = store_q[15:0];
    end else begin
      merged[7:0] = store_q[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      ready_q  <= 1'b1;
      resp_q   <= 1'b0;
      load_q   <= '0;
      addr_q   <= '0;
      funct3_q <= '0;
      store_q  <= '0;
      merge_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid_i && ready_q) begin
            addr_q   <= addr_i;
            funct3_q <= funct3_i;
            store_q  <= store_data_i;
            ready_q  <= 1'b0;
            if (!req_write_i) begin
              state_q <= StLoad;
            end else if (funct3_i[1]) begin
              state_q <= StWrite;
            end else begin
              state_q <= StMerge;
            end
          end
        end
        StLoad: begin
          load_q  <= load_ext;
          resp_q  <= 1'b1;
          state_q <= StDone;
        end
        StMerge: begin
          merge_q <= merged;
          state_q <= StWrite;
        end
        StWrite: begin
          resp_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          resp_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          resp_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_q;
  assign load_data_o  = load_q;
  assign mem_addr_o   = addr_q;

  // Reset gates the write strobe combinationally so an interrupted WRITE never reaches memory.
  assign mem_write_en_o   = (state_q == StWrite) && !rst_i;
  assign mem_write_data_o = (state_q == StWrite) ? (funct3_q[1] ? store_q : merge_q) : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small byte-array memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [64];
  logic [5:0] a0;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_write_i     (req_write),
    .funct3_i        (funct3),
    .addr_i          (addr),
    .store_data_i    (store_data),
    .resp_valid_o    (resp_valid),
    .load_data_o     (load_data),
    .mem_write_en_o  (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_write_data_o(mem_wdata),
    .mem_read_data_i (mem_rdata)
  );

  always #5 clk = ~clk;

  // 64-byte window; low address bits index it, wrapping inside the window.
  assign a0 = mem_addr[5:0];
  assign mem_rdata = {mem[a0 + 6'd3], mem[a0 + 6'd2], mem[a0 + 6'd1], mem[a0]};

  always @(negedge clk) begin
    if (mem_we) begin
      mem[a0]        = mem_wdata[7:0];
      mem[a0 + 6'd1] = mem_wdata[15:8];
      mem[a0 + 6'd2] = mem_wdata[23:16];
      mem[a0 + 6'd3] = mem_wdata[31:24];
    end
  end

  task automatic put_word(input int off, input logic [31:0] w);
    mem[off]     = w[7:0];
    mem[off + 1] = w[15:8];
    mem[off + 2] = w[23:16];
    mem[off + 3] = w[31:24];
  endtask

  // Present one request and return #1 after the accepting edge.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready got %b exp 1", req_ready);
    end
    req_write  = w;
    funct3     = f3;
    addr       = a;
    store_data = d;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
  endtask

  // lat counts cycles after acceptance (1 = the cycle right after the accepting edge).
  task automatic wait_resp(output int lat, output int we_cnt);
    lat    = 1;
    we_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_we) we_cnt++;
      if (resp_valid) return;
      @(posedge clk);
      #1;
      lat++;
    end
    lat = -1;
  endtask

  task automatic test_reset;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %b exp 1", req_ready);
    end
    tests++;
    if (resp_valid !== 1'b0) begin
      fails++; $display("FAIL reset_resp got %b exp 0", resp_valid);
    end
    tests++;
    if (mem_we !== 1'b0) begin
      fails++; $display("FAIL reset_we got %b exp 0", mem_we);
    end
    tests++;
    if (load_data !== 32'h0) begin
      fails++; $display("FAIL reset_load_data got %h exp 0", load_data);
    end
    tests++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      fails++; $display("FAIL reset_addr_wdata got %h/%h exp 0/0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_load_sign;
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFF80, 32'h0000FF80,
                              32'h1234FF80};
    int lat, wec;
    for (int k = 0; k < 5; k++) begin
      issue(1'b0, f3s[k], 32'h0001_0000, 32'h0);
      wait_resp(lat, wec);
      tests++;
      if (lat !== 2) begin
        fails++; $display("FAIL load_latency f3=%0d got %0d exp 2", f3s[k], lat);
      end
      tests++;
      if (load_data !== exps[k]) begin
        fails++; $display("FAIL load_data f3=%0d got %h exp %h", f3s[k], load_data, exps[k]);
      end
    end
  endtask

  task automatic test_subword_store;
    int lat, wec;
    // SB
    issue(1'b1, 3'b000, 32'h0001_0004, 32'h0000_00AA);
    wait_resp(lat, wec);
    tests++;
    if (lat !== 3) begin
      fails++; $display("FAIL sb_latency got %0d exp 3", lat);
    end
    tests++;
    if (wec !== 1) begin
      fails++; $display("FAIL sb_we_cycles got %0d exp 1", wec);
    end
    tests++;
    if (load_data !== 32'h1234FF80) begin
      fails++; $display("FAIL store_keeps_load_data got %h exp 1234ff80", load_data);
    end
    issue(1'b0, 3'b010, 32'h0001_0004, 32'h0);
    wait_resp(lat, wec);
    tests++;
    if (load_data !== 32'hDEADBEAA) begin
      fails++; $display("FAIL sb_readback got %h exp deadbeaa", load_data);
    end
    // SH; funct3[2] set to show it is ignored for stores
    issue(1'b1, 3'b101, 32'h0001_0004, 32'h0000_1234);
    wait_resp(lat, wec);
    tests++;
    if (lat !== 3 || wec !== 1) begin
      fails++; $display("FAIL sh_timing got lat %0d we %0d exp 3 1", lat, wec);
    end
    issue(1'b0, 3'b010, 32'h0001_0004, 32'h0);
    wait_resp(lat, wec);
    tests++;
    if (load_data !== 32'hDEAD1234) begin
      fails++; $display("FAIL sh_readback got %h exp dead1234", load_data);
    end
  endtask

  task automatic test_misaligned_sw;
    int lat, wec;
    issue(1'b1, 3'b010, 32'h0001_0001, 32'hCAFEBABE);
    wait_resp(lat, wec);
    tests++;
    if (lat !== 2 || wec !== 1) begin
      fails++; $display("FAIL sw_timing got lat %0d we %0d exp 2 1", lat, wec);
    end
    tests++;
    if ({mem[4], mem[3], mem[2], mem[1]} !== 32'hCAFEBABE) begin
      fails++;
      $display("FAIL sw_misaligned_bytes got %h exp cafebabe", {mem[4], mem[3], mem[2], mem[1]});
    end
    tests++;
    if (mem[0] !== 8'h80 || mem[5] !== 8'h12) begin
      fails++; $display("FAIL sw_neighbours got %h/%h exp 80/12", mem[0], mem[5]);
    end
  endtask

  task automatic test_reset_in_write;
    int pulses = 0;
    issue(1'b1, 3'b010, 32'h0001_0008, 32'h5555_5555);
    rst = 1'b1;
    #1;
    tests++;
    if (mem_we !== 1'b0) begin
      fails++; $display("FAIL rst_write_we got %b exp 0", mem_we);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL rst_write_idle got ready %b resp %b exp 1 0", req_ready, resp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) pulses++;
      @(posedge clk);
      #1;
    end
    tests++;
    if (pulses !== 0) begin
      fails++; $display("FAIL rst_write_no_resp got %0d exp 0", pulses);
    end
    tests++;
    if ({mem[11], mem[10], mem[9], mem[8]} !== 32'h11111111) begin
      fails++;
      $display("FAIL rst_write_mem got %h exp 11111111", {mem[11], mem[10], mem[9], mem[8]});
    end
  endtask

  task automatic test_busy;
    logic [31:0] addrs [3] = '{32'h0001_000C, 32'h0001_0010, 32'h0001_0014};
    logic [31:0] exps  [3] = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
    int acc_cyc [3] = '{0, 0, 0};
    int k_acc = 0;
    int k_resp = 0;
    int cyc = 0;
    req_write = 1'b0;
    funct3    = 3'b010;
    req_valid = 1'b1;
    while (k_resp < 3 && cyc < 40) begin
      if (resp_valid) begin
        tests++;
        if (load_data !== exps[k_resp]) begin
          fails++; $display("FAIL busy_data%0d got %h exp %h", k_resp, load_data, exps[k_resp]);
        end
        k_resp++;
      end
      if (req_ready && k_acc < 3) begin
        addr = addrs[k_acc];
        acc_cyc[k_acc] = cyc;
        k_acc++;
      end else if (req_ready) begin
        req_valid = 1'b0;
      end else begin
        addr = 32'h0001_0000 + 32'(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    req_valid = 1'b0;
    tests++;
    if (k_resp !== 3) begin
      fails++; $display("FAIL busy_timeout got %0d responses exp 3", k_resp);
    end
    tests++;
    if (acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3) begin
      fails++;
      $display("FAIL busy_spacing got %0d,%0d exp 3,3", acc_cyc[1] - acc_cyc[0],
               acc_cyc[2] - acc_cyc[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    put_word(0, 32'h1234FF80);
    put_word(4, 32'hDEADBEEF);
    put_word(8, 32'h11111111);
    put_word(12, 32'hA1A2A3A4);
    put_word(16, 32'hB1B2B3B4);
    put_word(20, 32'hC1C2C3C4);
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset;
    test_load_sign;
    test_subword_store;
    test_misaligned_sw;
    test_reset_in_write;
    test_busy;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
